// File: rtl/irq_router.sv
// irq_router: collects active-low slot interrupt requests, synchronizes and
// masks them, and raises one CPU interrupt at a time. Slots are granted round
// robin. The grant is held through the Z80-style acknowledge cycle, and a
// short hold-off follows each acknowledge.
module irq_router #(
    parameter int NUM_SLOTS   = 5,
    parameter int HOLDOFF_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SLOTS-1:0] slot_irq_n,
    input  logic [NUM_SLOTS-1:0] irq_mask,
    input  logic                 iorq_n,
    input  logic                 m1_n,
    output logic                 cpu_int_n,
    output logic                 irq_int_active,
    output logic [2:0]           irq_int_slot,
    output logic                 irq_vec_cycle,
    output logic [NUM_SLOTS-1:0] irq_pending
);

    localparam int PTR_W = 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_ACK     = 2'd2,
        S_HOLDOFF = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_SLOTS-1:0]   sync1_q, sync1_d;
    logic [NUM_SLOTS-1:0]   sync2_q, sync2_d;
    logic [NUM_SLOTS-1:0]   pending_q, pending_d;
    logic                   cpu_int_n_q, cpu_int_n_d;
    logic                   active_q, active_d;
    logic [PTR_W-1:0]       slot_q, slot_d;
    logic                   vec_q, vec_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [3:0]             cnt_q, cnt_d;

    logic [NUM_SLOTS-1:0]   pend;
    logic                   ack_cycle;
    logic                   grant_found;
    logic [PTR_W-1:0]       grant_idx;

    // Masked, synchronized request vector and the acknowledge decode.
    assign pend      = ~sync2_q & irq_mask;
    assign ack_cycle = !iorq_n && !m1_n;

    // Round-robin search: first pending slot at or above rr_ptr, wrapping.
    always_comb begin : grant_scan
        logic [PTR_W:0] cand;
        // NOTE: every variable written here gets a default first, so no path
        // can leave it unassigned and infer a latch.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_SLOTS)) begin
                cand = cand - (PTR_W+1)'(NUM_SLOTS);
            end
            if (!grant_found && pend[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // Next-state and registered-output logic for the grant/acknowledge FSM.
    always_comb begin
        sync1_d     = slot_irq_n;
        sync2_d     = sync1_q;
        pending_d   = pend;
        state_d     = state_q;
        cpu_int_n_d = cpu_int_n_q;
        active_d    = active_q;
        slot_d      = slot_q;
        vec_d       = vec_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                // A vector fetch with nothing latched is spurious: flag it so
                // the address decoder returns 0xFF, and do not grant under it.
                vec_d = ack_cycle;
                if (!ack_cycle && grant_found) begin
                    state_d     = S_ASSERT;
                    slot_d      = grant_idx;
                    active_d    = 1'b1;
                    cpu_int_n_d = 1'b0;
                end
            end
            S_ASSERT: begin
                // Acknowledge wins over a withdrawal seen on the same edge.
                if (ack_cycle) begin
                    state_d     = S_ACK;
                    vec_d       = 1'b1;
                    cpu_int_n_d = 1'b1;
                end else if (!pend[slot_q]) begin
                    state_d     = S_IDLE;
                    cpu_int_n_d = 1'b1;
                    active_d    = 1'b0;
                end
            end
            S_ACK: begin
                if (iorq_n) begin
                    state_d  = S_HOLDOFF;
                    vec_d    = 1'b0;
                    active_d = 1'b0;
                    rr_ptr_d = (slot_q == PTR_W'(NUM_SLOTS - 1)) ? '0 : slot_q + 1'b1;
                    cnt_d    = 4'(HOLDOFF_CYC - 1);
                end
            end
            S_HOLDOFF: begin
                vec_d = ack_cycle;
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sync1_q     <= '1;
            sync2_q     <= '1;
            pending_q   <= '0;
            cpu_int_n_q <= 1'b1;
            active_q    <= 1'b0;
            slot_q      <= '0;
            vec_q       <= 1'b0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            pending_q   <= pending_d;
            cpu_int_n_q <= cpu_int_n_d;
            active_q    <= active_d;
            slot_q      <= slot_d;
            vec_q       <= vec_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cpu_int_n      = cpu_int_n_q;
    assign irq_int_active = active_q;
    assign irq_int_slot   = slot_q;
    assign irq_vec_cycle  = vec_q;
    assign irq_pending    = pending_q;

endmodule

// File: tb/tb_irq_router.sv
// Directed testbench for irq_router. Inputs change 1 ns after a rising
// edge; outputs are sampled at that same point, which is away from the edge.
// Output bundle used in checks: {cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle}.
module tb_irq_router;

    localparam int NUM_SLOTS   = 5;
    localparam int HOLDOFF_CYC = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_SLOTS-1:0] slot_irq_n;
    logic [NUM_SLOTS-1:0] irq_mask;
    logic                 iorq_n;
    logic                 m1_n;
    logic                 cpu_int_n;
    logic                 irq_int_active;
    logic [2:0]           irq_int_slot;
    logic                 irq_vec_cycle;
    logic [NUM_SLOTS-1:0] irq_pending;

    int total = 0;
    int bad   = 0;

    irq_router #(.NUM_SLOTS(NUM_SLOTS), .HOLDOFF_CYC(HOLDOFF_CYC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .slot_irq_n     (slot_irq_n),
        .irq_mask       (irq_mask),
        .iorq_n         (iorq_n),
        .m1_n           (m1_n),
        .cpu_int_n      (cpu_int_n),
        .irq_int_active (irq_int_active),
        .irq_int_slot   (irq_int_slot),
        .irq_vec_cycle  (irq_vec_cycle),
        .irq_pending    (irq_pending)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Puts every input at its idle value and applies one reset edge.
    task automatic apply_reset();
        rst_n      = 1'b0;
        slot_irq_n = '1;
        irq_mask   = '1;
        iorq_n     = 1'b1;
        m1_n       = 1'b1;
        tick(1);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        slot_irq_n = '1;
        irq_mask   = '1;
        iorq_n     = 1'b1;
        m1_n       = 1'b1;
        tick(2);
        total++;
        if ({cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_outputs: got %b expected 100000",
                     {cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle});
        end
        total++;
        if (irq_pending !== 5'b00000) begin
            bad++;
            $display("FAIL reset_pending: got %b expected 00000", irq_pending);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        slot_irq_n = 5'b11011;
        tick(4);
        total++;
        if ({cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle} !== 6'b010100) begin
            bad++;
            $display("FAIL single_assert: got %b expected 010100",
                     {cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle});
        end
        total++;
        if (irq_pending !== 5'b00100) begin
            bad++;
            $display("FAIL single_pending: got %b expected 00100", irq_pending);
        end
        iorq_n     = 1'b0;
        m1_n       = 1'b0;
        slot_irq_n = '1;
        tick(1);
        total++;
        if ({cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle} !== 6'b110101) begin
            bad++;
            $display("FAIL single_ack: got %b expected 110101",
                     {cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle});
        end
        tick(1);
        total++;
        if ({cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle} !== 6'b110101) begin
            bad++;
            $display("FAIL single_ack_held: got %b expected 110101",
                     {cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle});
        end
        iorq_n = 1'b1;
        m1_n   = 1'b1;
        tick(1);
        total++;
        if ({cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle} !== 6'b100100) begin
            bad++;
            $display("FAIL single_release: got %b expected 100100",
                     {cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle});
        end
        total++;
        if (dut.rr_ptr_q !== 3'd3) begin
            bad++;
            $display("FAIL single_rr_ptr: got %0d expected 3", dut.rr_ptr_q);
        end
        tick(3);
        total++;
        if ({cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle} !== 6'b100100) begin
            bad++;
            $display("FAIL single_quiet: got %b expected 100100",
                     {cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle});
        end
    endtask

    task automatic test_round_robin();
        int exp_slot [3];
        int gap;
        exp_slot[0] = 0;
        exp_slot[1] = 3;
        exp_slot[2] = 0;
        apply_reset();
        slot_irq_n = 5'b10110;
        for (int k = 0; k < 3; k++) begin
            gap = 0;
            while (cpu_int_n !== 1'b0 && gap < 20) begin
                tick(1);
                gap++;
            end
            total++;
            if ((k == 0) ? (gap > 4) : (gap != HOLDOFF_CYC + 1)) begin
                bad++;
                $display("FAIL rr_gap_%0d: got %0d cycles expected %0d", k, gap,
                         (k == 0) ? 3 : HOLDOFF_CYC + 1);
            end
            total++;
            if ({irq_int_active, irq_int_slot} !== {1'b1, 3'(exp_slot[k])}) begin
                bad++;
                $display("FAIL rr_grant_%0d: got active=%b slot=%0d expected active=1 slot=%0d",
                         k, irq_int_active, irq_int_slot, exp_slot[k]);
            end
            iorq_n = 1'b0;
            m1_n   = 1'b0;
            tick(1);
            iorq_n = 1'b1;
            m1_n   = 1'b1;
            tick(1);
            total++;
            if ({cpu_int_n, irq_int_active, irq_vec_cycle} !== 3'b100) begin
                bad++;
                $display("FAIL rr_holdoff_%0d: got %b expected 100", k,
                         {cpu_int_n, irq_int_active, irq_vec_cycle});
            end
        end
    endtask

    task automatic test_withdraw();
        apply_reset();
        slot_irq_n = 5'b01111;
        tick(3);
        total++;
        if ({cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle} !== 6'b011000) begin
            bad++;
            $display("FAIL withdraw_assert: got %b expected 011000",
                     {cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle});
        end
        slot_irq_n = '1;
        tick(3);
        total++;
        if ({cpu_int_n, irq_int_active, irq_vec_cycle} !== 3'b100) begin
            bad++;
            $display("FAIL withdraw_drop: got %b expected 100",
                     {cpu_int_n, irq_int_active, irq_vec_cycle});
        end
        iorq_n = 1'b0;
        m1_n   = 1'b0;
        tick(2);
        total++;
        if ({cpu_int_n, irq_int_active, irq_vec_cycle} !== 3'b101) begin
            bad++;
            $display("FAIL spurious_ack: got %b expected 101",
                     {cpu_int_n, irq_int_active, irq_vec_cycle});
        end
        iorq_n = 1'b1;
        m1_n   = 1'b1;
        tick(1);
        total++;
        if ({cpu_int_n, irq_int_active, irq_vec_cycle} !== 3'b100) begin
            bad++;
            $display("FAIL spurious_end: got %b expected 100",
                     {cpu_int_n, irq_int_active, irq_vec_cycle});
        end
    endtask

    task automatic test_mask();
        apply_reset();
        irq_mask   = 5'b11101;
        slot_irq_n = 5'b11101;
        tick(4);
        total++;
        if ({irq_pending, cpu_int_n} !== 6'b000001) begin
            bad++;
            $display("FAIL mask_blocked: got pending=%b cpu_int_n=%b expected pending=00000 cpu_int_n=1",
                     irq_pending, cpu_int_n);
        end
        irq_mask = 5'b11111;
        tick(1);
        total++;
        if (irq_pending !== 5'b00010) begin
            bad++;
            $display("FAIL mask_pending: got %b expected 00010", irq_pending);
        end
        total++;
        if ({cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle} !== 6'b010010) begin
            bad++;
            $display("FAIL mask_grant: got %b expected 010010",
                     {cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle});
        end
    endtask

    task automatic test_frozen();
        apply_reset();
        slot_irq_n = 5'b10111;
        tick(3);
        total++;
        if ({cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle} !== 6'b010110) begin
            bad++;
            $display("FAIL frozen_assert: got %b expected 010110",
                     {cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle});
        end
        slot_irq_n = 5'b10110;
        tick(3);
        total++;
        if ({cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle} !== 6'b010110) begin
            bad++;
            $display("FAIL frozen_hold: got %b expected 010110",
                     {cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle});
        end
        iorq_n = 1'b0;
        m1_n   = 1'b1;
        tick(1);
        total++;
        if ({cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle} !== 6'b010110) begin
            bad++;
            $display("FAIL plain_io: got %b expected 010110",
                     {cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle});
        end
        m1_n = 1'b0;
        tick(1);
        total++;
        if ({cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle} !== 6'b110111) begin
            bad++;
            $display("FAIL frozen_ack: got %b expected 110111",
                     {cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle});
        end
        iorq_n = 1'b1;
        m1_n   = 1'b1;
        tick(1);
        total++;
        if ({cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle} !== 6'b100110) begin
            bad++;
            $display("FAIL frozen_release: got %b expected 100110",
                     {cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle});
        end
        tick(HOLDOFF_CYC + 1);
        total++;
        if ({cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle} !== 6'b010000) begin
            bad++;
            $display("FAIL frozen_next_wrap: got %b expected 010000",
                     {cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle});
        end
    endtask

    task automatic test_reset_mid_ack();
        apply_reset();
        slot_irq_n = 5'b01101;
        tick(3);
        total++;
        if ({cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle} !== 6'b010010) begin
            bad++;
            $display("FAIL midack_first: got %b expected 010010",
                     {cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle});
        end
        iorq_n = 1'b0;
        m1_n   = 1'b0;
        tick(1);
        iorq_n = 1'b1;
        m1_n   = 1'b1;
        tick(HOLDOFF_CYC + 2);
        total++;
        if ({cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle} !== 6'b011000) begin
            bad++;
            $display("FAIL midack_second: got %b expected 011000",
                     {cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle});
        end
        iorq_n = 1'b0;
        m1_n   = 1'b0;
        tick(1);
        total++;
        if ({cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle} !== 6'b111001) begin
            bad++;
            $display("FAIL midack_in_ack: got %b expected 111001",
                     {cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle});
        end
        rst_n = 1'b0;
        tick(1);
        total++;
        if ({cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle, irq_pending} !== 11'b100000_00000) begin
            bad++;
            $display("FAIL midack_reset: got %b expected 10000000000",
                     {cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle, irq_pending});
        end
        rst_n  = 1'b1;
        iorq_n = 1'b1;
        m1_n   = 1'b1;
        tick(3);
        total++;
        if ({cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle} !== 6'b010010) begin
            bad++;
            $display("FAIL midack_regrant: got %b expected 010010",
                     {cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_withdraw();
        test_mask();
        test_frozen();
        test_reset_mid_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/irq_router.md
IRQ_ROUTER -- requirements
Module: irq_router

Interface
REQ-001 Parameter NUM_SLOTS, default 5: number of Dock device slots.
REQ-002 Parameter HOLDOFF_CYC, default 2: post-acknowledge hold-off length in clk cycles; legal range 1..15.
REQ-003 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 Port slot_irq_n, input, NUM_SLOTS: per-slot interrupt requests, active-low level, asynchronous to clk.
REQ-006 Port irq_mask, input, NUM_SLOTS: per-slot enable; 1 = slot may interrupt.
REQ-007 Port iorq_n, input, 1: CPU /IORQ, active-low.
REQ-008 Port m1_n, input, 1: CPU /M1; iorq_n=0 with m1_n=0 marks an interrupt-acknowledge (vector) cycle.
REQ-009 Port cpu_int_n, output, 1: interrupt request to CPU, active-low.
REQ-010 Port irq_int_active, output, 1: an interrupt is latched and being serviced; feeds addr_decoder.
REQ-011 Port irq_int_slot, output, 3: slot index of the latched interrupt; feeds addr_decoder.
REQ-012 Port irq_vec_cycle, output, 1: vector-fetch cycle in progress; feeds addr_decoder.
REQ-013 Port irq_pending, output, NUM_SLOTS: synchronized requests ANDed with irq_mask, 1 = pending.

Function
REQ-014 Each slot_irq_n bit passes through a 2-flop synchronizer; only synchronized values are used internally.
REQ-015 pend = ~sync_irq_n & irq_mask; irq_pending is pend, registered, 1 cycle after the second sync flop.
REQ-016 FSM states: IDLE, ASSERT, ACK, HOLDOFF.
REQ-017 IDLE: if pend != 0, grant the first set bit at or after rr_ptr, scanning upward with wrap from NUM_SLOTS-1 to 0; enter ASSERT next cycle.
REQ-018 On entry to ASSERT: irq_int_slot <= granted index, irq_int_active <= 1, cpu_int_n <= 0, in the same edge.
REQ-019 ASSERT: granted slot frozen; new or higher-ranked requests do not change irq_int_slot.
REQ-020 ASSERT: if pend[irq_int_slot] drops (request withdrawn or masked) before acknowledge, go to IDLE; cpu_int_n <= 1, irq_int_active <= 0; rr_ptr unchanged.
REQ-021 ASSERT: iorq_n=0 and m1_n=0 sampled -> ACK; irq_vec_cycle <= 1, cpu_int_n <= 1, irq_int_active stays 1. Acknowledge takes precedence over a simultaneous withdrawal.
REQ-022 ACK: held while iorq_n=0; on iorq_n sampled 1 -> HOLDOFF; irq_vec_cycle <= 0, irq_int_active <= 0, rr_ptr <= (irq_int_slot+1) mod NUM_SLOTS.
REQ-023 HOLDOFF: counter counts HOLDOFF_CYC cycles, during which no grant is made; then IDLE. irq_int_slot retains its last value.
REQ-024 Acknowledge sampled in IDLE or HOLDOFF (spurious): irq_vec_cycle <= 1 while iorq_n=0 and m1_n=0, irq_int_active stays 0, no state change, so addr_decoder drives 0xFF.
REQ-025 iorq_n=0 with m1_n=1 is an ordinary I/O cycle and does not affect the FSM.
REQ-026 All outputs are registered; there is no combinational path from any input to any output.

Reset
REQ-027 rst_n=0 at a clk edge: state <= IDLE, cpu_int_n <= 1, irq_int_active <= 0, irq_int_slot <= 0, irq_vec_cycle <= 0, irq_pending <= 0, rr_ptr <= 0, sync flops <= all 1, holdoff counter <= 0.
REQ-028 Reset asserted in any state, including mid-ACK, aborts immediately to the REQ-027 values, whatever iorq_n/m1_n are doing.

Verification
REQ-029 Single request: mask=5'b11111, slot_irq_n[2]=0 -> cpu_int_n=0, irq_int_active=1, irq_int_slot=2 by the 4th edge; IORQ+M1 ack -> irq_vec_cycle=1, cpu_int_n=1; IORQ high -> active=0, rr_ptr=3.
REQ-030 Round-robin: slots 0 and 3 held low continuously -> grant order 0, 3, 0 across three ack cycles, with HOLDOFF_CYC idle cycles between them.
REQ-031 Withdrawal: slot 4 requests, then releases before ack -> irq_int_active/cpu_int_n return to 0/1; a later ack is spurious (vec_cycle=1, active=0).
REQ-032 Masking: irq_mask=5'b11101 and slot 1 low -> irq_pending=0 and no cpu_int_n; setting mask bit 1 -> request issued.
REQ-033 Frozen grant: slot 3 granted, then slot 0 asserts before ack -> irq_int_slot stays 3 through ACK.
REQ-034 Reset mid-ACK: rst_n=0 while iorq_n=m1_n=0 -> next edge all outputs at REQ-027 values; after release, a pending slot is re-granted from rr_ptr=0.
